// File: rtl/aurora_adc_recv.sv
// Aurora RX deframer: checks the start flag and packet framing, then rebuilds
// the 128-bit ADC words and 64-bit heads from the 9-beat block layout.
module aurora_adc_recv #(
    parameter int                 DATA_WD    = 128,
    parameter int                 HEAD_WD    = 64,
    parameter int                 BLK_NUM    = 32,
    parameter logic [DATA_WD-1:0] START_FLAG = 128'hAABBCCDD_AA55FF00_55AA0001_00000002
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_rst,
    input  logic [DATA_WD-1:0]   s_axis_tdata,
    input  logic [DATA_WD/8-1:0] s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    input  logic                 adc_fifo_afull,
    input  logic                 head_fifo_afull,
    output logic                 adc_wr,
    output logic [DATA_WD-1:0]   adc_dout,
    output logic                 head_wr,
    output logic [HEAD_WD-1:0]   head_dout,
    output logic                 flag_ok,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          err_cnt,
    output logic [1:0]           dbg_state_o
);
    localparam int BLK_WD = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;
    localparam logic [BLK_WD-1:0] BLK_LAST = BLK_WD'(BLK_NUM - 1);

    typedef enum logic [1:0] {
        WAIT_FLAG = 2'd0,
        WAIT_SOP  = 2'd1,
        BODY      = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           beat_q, beat_d;
    logic [BLK_WD-1:0]    blk_q, blk_d;
    logic [HEAD_WD-1:0]   stash_q, stash_d;
    logic                 flag_q, flag_d;
    logic [15:0]          pkt_q, pkt_d;
    logic [15:0]          err_q, err_d;
    logic                 adc_wr_q, adc_wr_d;
    logic [DATA_WD-1:0]   adc_dout_q, adc_dout_d;
    logic                 head_wr_q, head_wr_d;
    logic [HEAD_WD-1:0]   head_dout_q, head_dout_d;

    logic                 acc;
    logic                 process;
    logic                 err_inc;
    logic                 is_final;
    logic [3:0]           eff_beat;
    logic [BLK_WD-1:0]    eff_blk;
    logic [HEAD_WD-1:0]   lo, hi;

    assign s_axis_tready = ~adc_fifo_afull & ~head_fifo_afull;
    assign acc           = s_axis_tvalid & s_axis_tready;
    assign lo            = s_axis_tdata[HEAD_WD-1:0];
    assign hi            = s_axis_tdata[DATA_WD-1:HEAD_WD];

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        blk_d       = blk_q;
        stash_d     = stash_q;
        flag_d      = flag_q;
        pkt_d       = pkt_q;
        err_d       = err_q;
        adc_wr_d    = 1'b0;
        adc_dout_d  = adc_dout_q;
        head_wr_d   = 1'b0;
        head_dout_d = head_dout_q;
        process     = 1'b0;
        err_inc     = 1'b0;
        is_final    = 1'b0;
        eff_beat    = beat_q;
        eff_blk     = blk_q;

        case (state_q)
            WAIT_FLAG: begin
                if (acc && s_axis_tdata == START_FLAG) begin
                    flag_d  = 1'b1;
                    state_d = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (acc) begin
                    if (s_axis_tuser) begin
                        process  = 1'b1;
                        eff_beat = 4'd0;
                        eff_blk  = '0;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            BODY: begin
                if (acc) begin
                    process = 1'b1;
                    // A stray tuser restarts the packet at this beat.
                    if (s_axis_tuser) begin
                        eff_beat = 4'd0;
                        eff_blk  = '0;
                        if (beat_q != 4'd0 || blk_q != '0) begin
                            err_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_d = WAIT_FLAG;
        endcase

        if (process) begin
            is_final = (eff_blk == BLK_LAST) && (eff_beat == 4'd8);
            case (eff_beat)
                4'd0: begin
                    head_dout_d = lo;
                    head_wr_d   = 1'b1;
                    stash_d     = hi;
                end
                4'd1, 4'd2, 4'd3: begin
                    adc_dout_d = {lo, stash_q};
                    adc_wr_d   = 1'b1;
                    stash_d    = hi;
                end
                4'd4: begin
                    adc_dout_d  = {lo, stash_q};
                    adc_wr_d    = 1'b1;
                    head_dout_d = hi;
                    head_wr_d   = 1'b1;
                end
                default: begin
                    adc_dout_d = s_axis_tdata;
                    adc_wr_d   = 1'b1;
                end
            endcase

            if (s_axis_tlast != is_final) begin
                err_inc = 1'b1;
            end

            if (s_axis_tlast || is_final) begin
                state_d = WAIT_SOP;
                beat_d  = 4'd0;
                blk_d   = '0;
                if (s_axis_tlast && is_final) begin
                    pkt_d = pkt_q + 16'd1;
                end
            end else begin
                state_d = BODY;
                if (eff_beat == 4'd8) begin
                    beat_d = 4'd0;
                    blk_d  = eff_blk + 1'b1;
                end else begin
                    beat_d = eff_beat + 4'd1;
                    blk_d  = eff_blk;
                end
            end
        end

        if (err_inc && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end

        if (cfg_rst) begin
            state_d     = WAIT_FLAG;
            beat_d      = 4'd0;
            blk_d       = '0;
            stash_d     = '0;
            flag_d      = 1'b0;
            pkt_d       = '0;
            err_d       = '0;
            adc_wr_d    = 1'b0;
            adc_dout_d  = '0;
            head_wr_d   = 1'b0;
            head_dout_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_FLAG;
            beat_q      <= 4'd0;
            blk_q       <= '0;
            stash_q     <= '0;
            flag_q      <= 1'b0;
            pkt_q       <= '0;
            err_q       <= '0;
            adc_wr_q    <= 1'b0;
            adc_dout_q  <= '0;
            head_wr_q   <= 1'b0;
            head_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            blk_q       <= blk_d;
            stash_q     <= stash_d;
            flag_q      <= flag_d;
            pkt_q       <= pkt_d;
            err_q       <= err_d;
            adc_wr_q    <= adc_wr_d;
            adc_dout_q  <= adc_dout_d;
            head_wr_q   <= head_wr_d;
            head_dout_q <= head_dout_d;
        end
    end

    assign adc_wr      = adc_wr_q;
    assign adc_dout    = adc_dout_q;
    assign head_wr     = head_wr_q;
    assign head_dout   = head_dout_q;
    assign flag_ok     = flag_q;
    assign pkt_cnt     = pkt_q;
    assign err_cnt     = err_q;
    assign dbg_state_o = state_q;

    logic unused_keep;
    assign unused_keep = ^s_axis_tkeep;

endmodule

// File: tb/tb_aurora_adc_recv.sv
// Bench for aurora_adc_recv: scenario table plus hand-written reset and
// cfg_rst sequences, with a scoreboard fed from the sender-side word layout.
`timescale 1ns/1ps
module tb_aurora_adc_recv;
    localparam logic [127:0] FLAG = 128'hAABBCCDD_AA55FF00_55AA0001_00000002;
    localparam int PKT_BEATS = 288;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_rst = 1'b0;
    logic [127:0] tdata = '0;
    logic [15:0]  tkeep = '1;
    logic         tvalid = 1'b0;
    logic         tready;
    logic         tlast = 1'b0;
    logic         tuser = 1'b0;
    logic         adc_afull = 1'b0;
    logic         head_afull = 1'b0;
    logic         adc_wr, head_wr, flag_ok;
    logic [127:0] adc_dout;
    logic [63:0]  head_dout;
    logic [15:0]  pkt_cnt, err_cnt;
    logic [1:0]   dbg_state;

    aurora_adc_recv dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .adc_fifo_afull(adc_afull), .head_fifo_afull(head_afull),
        .adc_wr(adc_wr), .adc_dout(adc_dout), .head_wr(head_wr), .head_dout(head_dout),
        .flag_ok(flag_ok), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [63:0]  exp_head_q[$];
    int  adc_wr_cnt = 0;
    int  head_wr_cnt = 0;
    bit  gap_en = 0;
    bit  bp_en = 0;
    bit  exp_en = 1;
    int  seq = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        check("tready", {127'd0, tready}, {127'd0, ~(adc_afull | head_afull)});
        if (adc_wr) begin
            adc_wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL adc_extra_write: got %0h expected no write", adc_dout);
            end else begin
                check("adc_data", adc_dout, exp_q.pop_front());
            end
        end
        if (head_wr) begin
            head_wr_cnt++;
            if (exp_head_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL head_extra_write: got %0h expected no write", head_dout);
            end else begin
                check("head_data", {64'd0, head_dout}, {64'd0, exp_head_q.pop_front()});
            end
        end
    end

    // afull toggles every 3 cycles while backpressure is enabled
    initial begin
        int bp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bp_cnt++;
                if (bp_cnt % 3 == 0) adc_afull = ~adc_afull;
            end
        end
    end

    // ---------------- stimulus patterns ----------------
    function automatic logic [127:0] adc_w(input int p, input int k);
        logic [15:0] pp, kk;
        pp = p[15:0];
        kk = k[15:0];
        return {16'hADC0, pp, kk, 16'h5A5A, ~pp, ~kk, pp ^ kk, 16'h0F0F};
    endfunction

    function automatic logic [63:0] head_w(input int p, input int h);
        logic [15:0] pp, hh;
        pp = p[15:0];
        hh = h[15:0];
        return {16'hEAD0, pp, hh, ~hh};
    endfunction

    // Sender packing: the 64-bit halves of words 0..3 straddle beats 0..4.
    task automatic make_beat(input int p, input int blk, input int b, output logic [127:0] d);
        logic [127:0] a_prev, a_cur;
        logic [63:0]  h;
        int a0, h0;
        a0 = blk * 8;
        h0 = blk * 2;
        if (b == 0) begin
            a_cur = adc_w(p, a0); h = head_w(p, h0);
            d = {a_cur[63:0], h};
            if (exp_en) exp_head_q.push_back(h);
        end else if (b <= 3) begin
            a_prev = adc_w(p, a0 + b - 1); a_cur = adc_w(p, a0 + b);
            d = {a_cur[63:0], a_prev[127:64]};
            if (exp_en) exp_q.push_back(a_prev);
        end else if (b == 4) begin
            a_prev = adc_w(p, a0 + 3); h = head_w(p, h0 + 1);
            d = {h, a_prev[127:64]};
            if (exp_en) begin
                exp_q.push_back(a_prev);
                exp_head_q.push_back(h);
            end
        end else begin
            d = adc_w(p, a0 + b - 1);
            if (exp_en) exp_q.push_back(d);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [127:0] d, input logic u, input logic l);
        int n;
        tvalid = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
        n = 0;
        @(posedge clk);
        while (!tready && n < 2000) begin
            n++;
            @(posedge clk);
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got no accept expected accept within 2000 cycles");
        end
        #1;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    endtask

    // Sends the first nbeats of a packet; tlast on beat last_at (-1: never).
    task automatic send_pkt(input int nbeats, input int last_at);
        logic [127:0] d;
        int p;
        p = seq;
        seq++;
        for (int i = 0; i < nbeats; i++) begin
            make_beat(p, i / 9, i % 9, d);
            send_beat(d, i == 0, i == last_at);
        end
    endtask

    task automatic soft_reset();
        @(posedge clk); #1;
        cfg_rst = 1'b1;
        @(posedge clk); #1;
        cfg_rst = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string       name;
        int          garbage;
        int          partial;
        int          trunc_beats;
        bit          trunc_last;
        int          stray;
        int          good;
        bit          bp;
        logic [15:0] exp_pkt;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w_adc, w_head;
        vecs[0] = '{"one_packet",    0,  0,   0, 1'b0, 0, 1, 1'b0, 16'd1, 16'd0};
        vecs[1] = '{"pre_garbage",   5,  0,   0, 1'b0, 0, 1, 1'b0, 16'd1, 16'd0};
        vecs[2] = '{"early_tlast",   0,  0,  36, 1'b1, 0, 1, 1'b0, 16'd1, 16'd1};
        vecs[3] = '{"missing_tlast", 0,  0, 288, 1'b0, 2, 1, 1'b0, 16'd1, 16'd3};
        vecs[4] = '{"resync_tuser",  0, 20,   0, 1'b0, 0, 1, 1'b0, 16'd1, 16'd1};
        vecs[5] = '{"backpressure",  0,  0,   0, 1'b0, 0, 4, 1'b1, 16'd4, 16'd0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_adc_wr",    {127'd0, adc_wr},  128'd0);
        check("rst_head_wr",   {127'd0, head_wr}, 128'd0);
        check("rst_adc_dout",  adc_dout,          128'd0);
        check("rst_head_dout", {64'd0, head_dout}, 128'd0);
        check("rst_flag_ok",   {127'd0, flag_ok}, 128'd0);
        check("rst_pkt_cnt",   {112'd0, pkt_cnt}, 128'd0);
        check("rst_err_cnt",   {112'd0, err_cnt}, 128'd0);
        check("rst_state",     {126'd0, dbg_state}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            soft_reset();
            drain();
            exp_q.delete();
            exp_head_q.delete();
            gap_en = vecs[v].bp;
            bp_en  = vecs[v].bp;
            for (int g = 0; g < vecs[v].garbage; g++) begin
                send_beat({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            end
            send_beat(FLAG, 1'b0, 1'b0);
            if (vecs[v].partial > 0) send_pkt(vecs[v].partial, -1);
            if (vecs[v].trunc_beats > 0) begin
                send_pkt(vecs[v].trunc_beats, vecs[v].trunc_last ? vecs[v].trunc_beats - 1 : -1);
            end
            // the start flag after the first one counts as ordinary (stray) data
            for (int s = 0; s < vecs[v].stray; s++) send_beat(FLAG, 1'b0, 1'b0);
            for (int k = 0; k < vecs[v].good; k++) send_pkt(PKT_BEATS, PKT_BEATS - 1);
            bp_en = 1'b0;
            gap_en = 1'b0;
            drain();
            adc_afull = 1'b0;
            check({vecs[v].name, "_flag_ok"}, {127'd0, flag_ok}, 128'd1);
            check({vecs[v].name, "_pkt_cnt"}, {112'd0, pkt_cnt}, {112'd0, vecs[v].exp_pkt});
            check({vecs[v].name, "_err_cnt"}, {112'd0, err_cnt}, {112'd0, vecs[v].exp_err});
            check({vecs[v].name, "_state"},   {126'd0, dbg_state}, 128'd1);
            check({vecs[v].name, "_adc_left"},  128'(exp_q.size()), 128'd0);
            check({vecs[v].name, "_head_left"}, 128'(exp_head_q.size()), 128'd0);
        end

        // 256 ADC and 64 head writes for one clean packet
        soft_reset();
        drain();
        w_adc = adc_wr_cnt;
        w_head = head_wr_cnt;
        send_beat(FLAG, 1'b0, 1'b0);
        send_pkt(PKT_BEATS, PKT_BEATS - 1);
        drain();
        check("pkt_adc_writes",  128'(adc_wr_cnt - w_adc), 128'd256);
        check("pkt_head_writes", 128'(head_wr_cnt - w_head), 128'd64);

        // cfg_rst mid-packet (block 10), then a packet with no new flag
        soft_reset();
        drain();
        send_beat(FLAG, 1'b0, 1'b0);
        send_pkt(10 * 9 + 3, -1);
        drain();
        check("mid_state_body", {126'd0, dbg_state}, 128'd2);
        soft_reset();
        @(negedge clk);
        check("cfgrst_flag_ok", {127'd0, flag_ok}, 128'd0);
        check("cfgrst_pkt_cnt", {112'd0, pkt_cnt}, 128'd0);
        check("cfgrst_err_cnt", {112'd0, err_cnt}, 128'd0);
        check("cfgrst_state",   {126'd0, dbg_state}, 128'd0);
        exp_en = 1'b0;
        w_adc = adc_wr_cnt;
        w_head = head_wr_cnt;
        send_pkt(PKT_BEATS, PKT_BEATS - 1);
        drain();
        check("noflag_adc_writes",  128'(adc_wr_cnt - w_adc), 128'd0);
        check("noflag_head_writes", 128'(head_wr_cnt - w_head), 128'd0);
        check("noflag_pkt_cnt", {112'd0, pkt_cnt}, 128'd0);
        check("noflag_flag_ok", {127'd0, flag_ok}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
